mod_hazard_ctrl: RTL and testbench

MOD_HAZARD_CTRL -- requirements
Module: mod_hazard_ctrl

---
 rtl/mod_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_mod_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mod_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and a
// data-memory handshake FSM (IDLE/WAIT/FAULT) that freezes the whole pipe
// while an access is outstanding and latches a sticky fault on timeout.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module mod_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [`REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [`REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                       id_rs1_used_i,
    input  logic                       id_rs2_used_i,
    input  logic [`REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                       ex_mem_read_i,
    input  logic                       ex_branch_taken_i,
    input  logic                       mem_req_i,
    input  logic                       dmem_ack_i,
    output logic                       dmem_req_o,
    output logic                       stall_pc_o,
    output logic                       stall_if2id_o,
    output logic                       stall_id2ex_o,
    output logic                       stall_ex2mem_o,
    output logic                       stall_mem2wb_o,
    output logic                       flush_if2id_o,
    output logic                       flush_id2ex_o,
    output logic                       mem_fault_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } mem_state_e;

    // TIMEOUT_CYC is at most 255, so an 8-bit wait counter always suffices.
    localparam int         WCW       = 8;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

    mem_state_e       state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_busy;
    logic load_use;

    // Memory FSM next state, request output and busy indication.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dmem_req_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                dmem_req_o = mem_req_i;
                if (mem_req_i && !dmem_ack_i) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                dmem_req_o = 1'b1;
                // An ack on the final allowed cycle still completes the access.
                if (dmem_ack_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_FAULT: begin
                dmem_req_o = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_busy = (dmem_req_o && !dmem_ack_i) || (state_q == ST_FAULT);
    end

    // Load-use detection against the load currently in EX; x0 never hazards.
    always_comb begin
        load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                   ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                    (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
    end

    // Stall/flush priority: memory busy > taken branch > load-use.
    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if2id_o  = 1'b0;
        stall_id2ex_o  = 1'b0;
        stall_ex2mem_o = 1'b0;
        stall_mem2wb_o = 1'b0;
        flush_if2id_o  = 1'b0;
        flush_id2ex_o  = 1'b0;
        if (mem_busy) begin
            // EX is frozen too, so a pending branch is simply seen again later.
            stall_pc_o     = 1'b1;
            stall_if2id_o  = 1'b1;
            stall_id2ex_o  = 1'b1;
            stall_ex2mem_o = 1'b1;
            stall_mem2wb_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            flush_if2id_o = 1'b1;
            flush_id2ex_o = 1'b1;
        end else if (load_use) begin
            stall_pc_o    = 1'b1;
            stall_if2id_o = 1'b1;
            flush_id2ex_o = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_pc_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_fault_o = (state_q == ST_FAULT);
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mod_hazard_ctrl.sv
// Directed bench for mod_hazard_ctrl: each vector pushes its hand-computed
// expected outputs into a scoreboard queue; a monitor pops and compares on
// every falling edge. Built with TIMEOUT_CYC=4 and a 4-bit stall counter so
// the timeout and saturation boundaries are reachable in a few cycles.
`timescale 1ns/1ps

module tb_mod_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    // {dmem_req, stall_pc, if2id, id2ex, ex2mem, mem2wb, flush_if2id, flush_id2ex, fault}
    localparam logic [8:0] O_NONE  = 9'b0_00000_00_0;
    localparam logic [8:0] O_LU    = 9'b0_11000_01_0;
    localparam logic [8:0] O_BR    = 9'b0_00000_11_0;
    localparam logic [8:0] O_REQ   = 9'b1_00000_00_0;
    localparam logic [8:0] O_REQBR = 9'b1_00000_11_0;
    localparam logic [8:0] O_BUSY  = 9'b1_11111_00_0;
    localparam logic [8:0] O_FAULT = 9'b0_11111_00_1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
    logic          u1 = 1'b0, u2 = 1'b0, mr = 1'b0, br = 1'b0, mreq = 1'b0, ack = 1'b0;
    logic          dmem_req, s_pc, s_ifid, s_idex, s_exmem, s_memwb, f_ifid, f_idex, fault;
    logic [CW-1:0] scnt;

    typedef struct {
        logic [8:0]    o;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mod_hazard_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(u1), .id_rs2_used_i(u2),
        .ex_rd_i(rd), .ex_mem_read_i(mr), .ex_branch_taken_i(br),
        .mem_req_i(mreq), .dmem_ack_i(ack),
        .dmem_req_o(dmem_req),
        .stall_pc_o(s_pc), .stall_if2id_o(s_ifid), .stall_id2ex_o(s_idex),
        .stall_ex2mem_o(s_exmem), .stall_mem2wb_o(s_memwb),
        .flush_if2id_o(f_ifid), .flush_id2ex_o(f_idex),
        .mem_fault_o(fault), .stall_cnt_o(scnt)
    );

    // Monitor: outputs are combinational, so one expectation per cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = sb_q.pop_front();
            act = {dmem_req, s_pc, s_ifid, s_idex, s_exmem, s_memwb, f_ifid, f_idex, fault};
            n_checks++;
            if (act !== e.o) begin
                n_fail++;
                $display("FAIL %s outputs: got %b expected %b", e.name, act, e.o);
            end
            n_checks++;
            if (scnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, scnt, e.cnt);
            end
            $display("txn %-14s outs=%b cnt=%0d", e.name, act, scnt);
        end
    end

    // Apply one vector just after the rising edge (so reset changes are
    // asynchronous) and queue its expected outputs for this cycle.
    task automatic step(input logic r, input logic [4:0] a1, input logic au1,
                        input logic [4:0] a2, input logic au2, input logic [4:0] ard,
                        input logic amr, input logic abr, input logic areq, input logic aack,
                        input logic [8:0] eo, input int ecnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; rs1 = a1; u1 = au1; rs2 = a2; u2 = au2; rd = ard;
        mr = amr; br = abr; mreq = areq; ack = aack;
        e.o = eo; e.cnt = CW'(ecnt); e.name = nm;
        sb_q.push_back(e);
    endtask

    initial begin
        //    rst rs1 u1 rs2 u2 rd mr br req ack expected   cnt name
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, "reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, "idle");
        step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, O_LU,    0, "lu_rs1");
        step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, O_LU,    1, "lu_rs1_cnt");
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, O_NONE,  2, "lu_rd0");
        step(1, 3, 1, 7, 1, 7, 1, 0, 0, 0, O_LU,    2, "lu_rs2");
        step(1, 5, 0, 0, 0, 5, 1, 0, 0, 0, O_NONE,  3, "rs1_unused");
        step(1, 5, 1, 0, 0, 5, 0, 0, 0, 0, O_NONE,  3, "not_load");
        step(1, 5, 1, 0, 0, 5, 1, 1, 0, 0, O_BR,    3, "br_over_lu");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_REQ,   3, "zero_wait");
        // ack low three cycles then high; branch held meanwhile
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_BUSY,  3, "wait_req");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_BUSY,  4, "wait_1");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_BUSY,  5, "wait_2");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_REQBR, 6, "wait_ack_br");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  6, "idle_after");
        // ack on the last allowed WAIT cycle
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  6, "to_req");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  7, "to_w0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  8, "to_w1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  9, "to_w2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_REQ,  10, "to_ack_last");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 10, "to_no_fault");
        // drive the counter into saturation
        for (int i = 0; i < 7; i++)
            step(1, 9, 1, 0, 0, 9, 1, 0, 0, 0, O_LU, (10 + i > 15) ? 15 : 10 + i, "lu_sat");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 15, "sat_hold");
        // reset asserted mid-WAIT, between edges
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY, 15, "rw_req");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY, 15, "rw_wait");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, "rw_async_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, "rw_released");
        // ack never arrives: FAULT five cycles after the request
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  0, "f_req");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  1, "f_w0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  2, "f_w1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  3, "f_w2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUSY,  4, "f_w3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FAULT, 5, "fault");
        step(1, 5, 1, 0, 0, 5, 1, 1, 1, 1, O_FAULT, 6, "fault_sticky");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FAULT, 7, "fault_hold");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, "fault_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, "fault_cleared");
        // during reset the FSM is IDLE, so dmem_req follows mem_req
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BUSY,  0, "rst_req");
        step(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, O_LU,    0, "rst_lu");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, "final");

        // let the monitor drain, with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
